// File: rtl/scb_pkg.sv
// Shared decode constants and scoreboard types for the MIPS reference scoreboard.

package AluCtrlSig_pkg;
  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // R-type function codes
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_XOR    = 6'h26;
  localparam logic [5:0] F_NOR    = 6'h27;
  localparam logic [5:0] F_SLT    = 6'h2A;
endpackage

package scb_pkg;
  // How a queued entry is judged at commit
  typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BR, K_J, K_BAD} scb_kind_t;

  // Scoreboard run state
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;
endpackage

// File: rtl/scb_fifo.sv
// In-order synchronous FIFO for expected-result entries; pointers carry an
// extra wrap bit so full and empty are distinguishable.

module scb_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;
  T            mem [DEPTH];

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this edge, so a push is still accepted when full.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer advance; reset empties the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mips_scoreboard.sv
// Reference-model scoreboard: decodes issued instructions into expected
// results, queues them in order, and judges each CPU commit against the head.

module mips_scoreboard
  import scb_pkg::*;
  import AluCtrlSig_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int DM_ADDR_W   = 7,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [31:0]       iss_inst,
  input  logic [DATA_W-1:0] iss_rs_value,
  input  logic [DATA_W-1:0] iss_rt_value,
  output logic              iss_ready,
  input  logic              cmt_valid,
  input  logic [DATA_W-1:0] cmt_rd_value,
  input  logic [DATA_W-1:0] cmt_lw_data,
  input  logic              cmt_taken,
  input  logic [DATA_W-1:0] cmt_target,
  output logic              op_done,
  output logic              op_err,
  output logic [5:0]        err_opcode,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              overflow,
  output logic              underflow
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [5:0]        funct;
    scb_kind_t         kind;
    logic [DATA_W-1:0] exp_val;
    logic [DATA_W-1:0] exp_target;
    logic              exp_taken;
  } scb_entry_t;

  logic [0:0]        state;
  scb_entry_t        iss_entry;
  scb_entry_t        head;
  logic              full;
  logic              empty;
  logic [AW:0]       fifo_count;
  logic              push;
  logic              pop;
  logic              match;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] ls_addr;
  logic [DM_ADDR_W-1:0] dm_idx;
  logic [DATA_W-1:0] shadow_mem [2**DM_ADDR_W];
  logic              unused_bits;

  assign imm_sext = {{(DATA_W-16){iss_inst[15]}}, iss_inst[15:0]};
  assign ls_addr  = iss_rs_value + imm_sext;
  assign dm_idx   = ls_addr[DM_ADDR_W+1:2];

  assign iss_ready = !full && (state == S_RUN);
  assign pop       = cmt_valid && !empty && (state == S_RUN);
  // Issue at full is taken only when the same edge retires the head; otherwise it is dropped.
  assign push      = iss_valid && (state == S_RUN) && (!full || pop);

  assign unused_bits = ^{ls_addr[DATA_W-1:DM_ADDR_W+2], ls_addr[1:0], head.funct};

  // Decode the issued instruction into its expected-result entry
  always_comb begin
    iss_entry            = '0;
    iss_entry.opcode     = iss_inst[31:26];
    iss_entry.funct      = iss_inst[5:0];
    iss_entry.kind       = K_BAD;
    case (iss_inst[31:26])
      OP_RTYPE: begin
        iss_entry.kind = K_ALU;
        case (iss_inst[5:0])
          F_ADD:   iss_entry.exp_val = iss_rs_value + iss_rt_value;
          F_SUB:   iss_entry.exp_val = iss_rs_value - iss_rt_value;
          F_AND:   iss_entry.exp_val = iss_rs_value & iss_rt_value;
          F_OR:    iss_entry.exp_val = iss_rs_value | iss_rt_value;
          F_XOR:   iss_entry.exp_val = iss_rs_value ^ iss_rt_value;
          F_NOR:   iss_entry.exp_val = ~(iss_rs_value | iss_rt_value);
          F_SLT:   iss_entry.exp_val = {{(DATA_W-1){1'b0}},
                                        ($signed(iss_rs_value) < $signed(iss_rt_value))};
          default: iss_entry.kind = K_BAD;
        endcase
      end
      OP_ADDI: begin
        iss_entry.kind    = K_ALU;
        iss_entry.exp_val = ls_addr;
      end
      OP_LW: begin
        iss_entry.kind    = K_LW;
        iss_entry.exp_val = shadow_mem[dm_idx];
      end
      OP_SW:  iss_entry.kind = K_SW;
      OP_BEQ, OP_BNE: begin
        iss_entry.kind       = K_BR;
        iss_entry.exp_taken  = (iss_inst[31:26] == OP_BEQ) ?
                               (iss_rs_value == iss_rt_value) :
                               (iss_rs_value != iss_rt_value);
        iss_entry.exp_target = {imm_sext[DATA_W-3:0], 2'b00};
      end
      OP_J: begin
        iss_entry.kind       = K_J;
        iss_entry.exp_taken  = 1'b1;
        iss_entry.exp_target = {{(DATA_W-28){1'b0}}, iss_inst[25:0], 2'b00};
      end
      default: iss_entry.kind = K_BAD;
    endcase
  end

  scb_fifo #(
    .DEPTH (DEPTH),
    .T     (scb_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (iss_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Judge the CPU commit against the queue head
  always_comb begin
    match = 1'b0;
    case (head.kind)
      K_ALU:   match = (cmt_rd_value == head.exp_val);
      K_LW:    match = (cmt_lw_data == head.exp_val) && (cmt_rd_value == cmt_lw_data);
      K_SW:    match = 1'b1;
      K_BR:    match = (cmt_taken == head.exp_taken) &&
                       (!cmt_taken || (cmt_target == head.exp_target));
      K_J:     match = cmt_taken && (cmt_target == head.exp_target);
      default: match = 1'b0;
    endcase
  end

  // Shadow data memory: SW writes at its issue edge, never cleared by reset
  always_ff @(posedge clk) begin
    if (push && !reset && (iss_entry.kind == K_SW)) shadow_mem[dm_idx] <= iss_rt_value;
  end

  // Registered verdict pulses, counters, sticky flags and run/halt state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RUN;
      op_done    <= 1'b0;
      op_err     <= 1'b0;
      err_opcode <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      op_done <= 1'b0;
      op_err  <= 1'b0;
      if (iss_valid && (state == S_RUN) && !push) overflow <= 1'b1;
      if (cmt_valid && (fifo_count == '0)) underflow <= 1'b1;
      if (pop) begin
        if (match) begin
          op_done <= 1'b1;
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          op_err     <= 1'b1;
          err_opcode <= head.opcode;
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          if (STOP_ON_ERR != 0) state <= S_HALT;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_scoreboard.sv
// Bench for mips_scoreboard: directed cases plus random traffic, judged by an
// instruction-level reference model and an expected-verdict queue that a
// separate monitor drains whenever the DUT pulses.

module tb_mips_scoreboard;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2A;

  localparam int M_ALU = 0, M_LW = 1, M_SW = 2, M_BR = 3, M_J = 4, M_BAD = 5;

  typedef struct {
    int          kind;
    logic [5:0]  opcode;
    logic [31:0] val;
    logic [31:0] tgt;
    bit          taken;
  } mexp_t;

  typedef struct {
    bit         pass;
    logic [5:0] opcode;
  } chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT
  logic              reset = 1'b1;
  logic              iss_valid = 1'b0;
  logic [31:0]       iss_inst = '0;
  logic [DATA_W-1:0] iss_rs_value = '0, iss_rt_value = '0;
  logic              iss_ready;
  logic              cmt_valid = 1'b0;
  logic [DATA_W-1:0] cmt_rd_value = '0, cmt_lw_data = '0, cmt_target = '0;
  logic              cmt_taken = 1'b0;
  logic              op_done, op_err, overflow, underflow;
  logic [5:0]        err_opcode;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;

  // Halt-on-error DUT
  logic              h_reset = 1'b1;
  logic              h_iss_valid = 1'b0;
  logic [31:0]       h_iss_inst = '0;
  logic [DATA_W-1:0] h_iss_rs = '0, h_iss_rt = '0;
  logic              h_iss_ready;
  logic              h_cmt_valid = 1'b0;
  logic [DATA_W-1:0] h_cmt_rd = '0, h_cmt_lw = '0, h_cmt_target = '0;
  logic              h_cmt_taken = 1'b0;
  logic              h_op_done, h_op_err, h_overflow, h_underflow;
  logic [5:0]        h_err_opcode;
  logic [CNT_W-1:0]  h_pass_cnt, h_fail_cnt;

  int n_chk = 0, n_fail = 0;
  int mon_pass = 0, mon_fail = 0;

  mexp_t       mq[$];
  chk_t        cq[$];
  logic [31:0] mmem [128];

  mips_scoreboard #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DM_ADDR_W(7), .CNT_W(CNT_W), .STOP_ON_ERR(0)
  ) u_dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_inst(iss_inst),
    .iss_rs_value(iss_rs_value), .iss_rt_value(iss_rt_value), .iss_ready(iss_ready),
    .cmt_valid(cmt_valid), .cmt_rd_value(cmt_rd_value), .cmt_lw_data(cmt_lw_data),
    .cmt_taken(cmt_taken), .cmt_target(cmt_target),
    .op_done(op_done), .op_err(op_err), .err_opcode(err_opcode),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  mips_scoreboard #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DM_ADDR_W(7), .CNT_W(CNT_W), .STOP_ON_ERR(1)
  ) u_halt (
    .clk(clk), .reset(h_reset),
    .iss_valid(h_iss_valid), .iss_inst(h_iss_inst),
    .iss_rs_value(h_iss_rs), .iss_rt_value(h_iss_rt), .iss_ready(h_iss_ready),
    .cmt_valid(h_cmt_valid), .cmt_rd_value(h_cmt_rd), .cmt_lw_data(h_cmt_lw),
    .cmt_taken(h_cmt_taken), .cmt_target(h_cmt_target),
    .op_done(h_op_done), .op_err(h_op_err), .err_opcode(h_err_opcode),
    .pass_cnt(h_pass_cnt), .fail_cnt(h_fail_cnt),
    .overflow(h_overflow), .underflow(h_underflow)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {OP_R, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic int widx(input logic [31:0] rs, input logic [31:0] inst);
    logic [31:0] a;
    a = rs + sext16(inst[15:0]);
    return int'((a >> 2) % 128);
  endfunction

  // Instruction-level meaning of one issued instruction
  function automatic mexp_t model_issue(input logic [31:0] inst, input logic [31:0] rs,
                                        input logic [31:0] rt);
    mexp_t m;
    m.kind = M_BAD; m.opcode = inst[31:26]; m.val = 0; m.tgt = 0; m.taken = 0;
    case (inst[31:26])
      OP_R: begin
        m.kind = M_ALU;
        case (inst[5:0])
          6'h20: m.val = rs + rt;
          6'h22: m.val = rs - rt;
          6'h24: m.val = rs & rt;
          6'h25: m.val = rs | rt;
          6'h26: m.val = rs ^ rt;
          6'h27: m.val = ~(rs | rt);
          6'h2A: m.val = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
          default: m.kind = M_BAD;
        endcase
      end
      OP_ADDI: begin m.kind = M_ALU; m.val = rs + sext16(inst[15:0]); end
      OP_LW:   begin m.kind = M_LW;  m.val = mmem[widx(rs, inst)]; end
      OP_SW:   m.kind = M_SW;
      OP_BEQ:  begin m.kind = M_BR; m.taken = (rs == rt); m.tgt = sext16(inst[15:0]) * 4; end
      OP_BNE:  begin m.kind = M_BR; m.taken = (rs != rt); m.tgt = sext16(inst[15:0]) * 4; end
      OP_J:    begin m.kind = M_J;  m.taken = 1; m.tgt = {6'd0, inst[25:0]} * 4; end
      default: m.kind = M_BAD;
    endcase
    return m;
  endfunction

  // One clock of traffic: optional issue, optional commit of the model head
  // (correct result, or a deliberately wrong one when corrupt is set).
  task automatic step(input bit iv, input logic [31:0] inst, input logic [31:0] rs,
                      input logic [31:0] rt, input bit cv, input bit corrupt);
    mexp_t h, m;
    chk_t  c;
    bit popping, pushing, tk;
    logic [31:0] rd, lw, tg;
    popping = cv && (mq.size() > 0);
    pushing = iv && ((mq.size() < DEPTH) || popping);
    rd = $urandom; lw = $urandom; tg = $urandom; tk = 1'($urandom_range(0, 1));
    if (popping) begin
      h = mq[0];
      case (h.kind)
        M_ALU: rd = corrupt ? (h.val ^ 32'h1) : h.val;
        M_LW: begin
          lw = h.val; rd = h.val;
          if (corrupt) begin
            if ($urandom_range(0, 1) == 1) begin lw = h.val ^ 32'h1; rd = lw; end
            else rd = h.val ^ 32'h2;
          end
        end
        M_BR: begin
          tk = h.taken;
          if (h.taken) tg = h.tgt;
          if (corrupt) begin
            if (h.taken && ($urandom_range(0, 1) == 1)) tg = h.tgt ^ 32'h4;
            else tk = !h.taken;
          end
        end
        M_J: begin
          tk = 1; tg = h.tgt;
          if (corrupt) begin
            if ($urandom_range(0, 1) == 1) tk = 0;
            else tg = h.tgt ^ 32'h100;
          end
        end
        default: ;
      endcase
      c.pass   = (h.kind == M_SW) ? 1'b1 : (h.kind == M_BAD) ? 1'b0 : !corrupt;
      c.opcode = h.opcode;
      cq.push_back(c);
    end
    if (pushing) m = model_issue(inst, rs, rt);
    iss_valid = iv; iss_inst = inst; iss_rs_value = rs; iss_rt_value = rt;
    cmt_valid = cv; cmt_rd_value = rd; cmt_lw_data = lw; cmt_taken = tk; cmt_target = tg;
    @(posedge clk);
    if (popping) h = mq.pop_front();
    if (pushing) begin
      mq.push_back(m);
      if (m.kind == M_SW) mmem[widx(rs, inst)] = rt;
    end
    #1;
    iss_valid = 0; cmt_valid = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fns [7];
    int sel;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    sel = $urandom_range(0, 14);
    if (sel < 7)        return rtype(fns[sel]);
    else if (sel == 7)  return rtype(6'h01);
    else if (sel == 8)  return itype(OP_ADDI, 16'($urandom));
    else if (sel == 9)  return itype(OP_LW,   16'($urandom));
    else if (sel == 10) return itype(OP_SW,   16'($urandom));
    else if (sel == 11) return itype(OP_BEQ,  16'($urandom));
    else if (sel == 12) return itype(OP_BNE,  16'($urandom));
    else if (sel == 13) return {OP_J, 26'($urandom)};
    else                return {6'h3F, 26'($urandom)};
  endfunction

  function automatic logic [31:0] rand_val();
    if ($urandom_range(0, 1) == 1) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  task automatic main_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    mq.delete(); cq.delete();
    mon_pass = 0; mon_fail = 0;
  endtask

  // Monitor: every verdict pulse is matched against the oldest expectation
  always @(negedge clk) begin
    chk_t c;
    if (op_done || op_err) begin
      chk("pulse_expected", cq.size() != 0, 1);
      chk("pulse_onehot", op_done && op_err, 0);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        if (c.pass) mon_pass++; else mon_fail++;
        chk("verdict", op_done, c.pass);
        if (!c.pass) chk("err_opcode", err_opcode, c.opcode);
        chk("pass_cnt", pass_cnt, mon_pass);
        chk("fail_cnt", fail_cnt, mon_fail);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_op_done", op_done, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_err_opcode", err_opcode, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_iss_ready", iss_ready, 1);

    // Fill the whole shadow memory so later loads have defined data
    for (int i = 0; i < 128; i++)
      step(1, itype(OP_SW, 16'(i * 4)), 0, $urandom, i > 0, 0);
    step(0, 0, 0, 0, 1, 0);

    // ADD 5+7: correct commit, then a wrong one
    step(1, rtype(F_ADD), 5, 7, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("add_done_next_cycle", op_done, 1);
    step(1, rtype(F_ADD), 5, 7, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("add_err_next_cycle", op_err, 1);

    // Store then load the same address
    step(1, itype(OP_SW, 16'h0010), 0, 32'hDEADBEEF, 0, 0);
    step(1, itype(OP_LW, 16'h0010), 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("lw_after_sw", op_done, 1);
    step(1, itype(OP_LW, 16'h0010), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("lw_bad_data", op_err, 1);

    // Branches: BNE not taken, BEQ with negative offset, BEQ wrong target
    step(1, itype(OP_BNE, 16'h0004), 3, 3, 0, 0);
    step(1, itype(OP_BEQ, 16'hFFFF), 9, 9, 1, 0);
    step(1, itype(OP_BEQ, 16'hFFFF), 9, 9, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(1, {OP_J, 26'h3ABCDEF}, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    // Commit on empty queue, then signed SLT
    chk("no_underflow_yet", underflow, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("underflow_set", underflow, 1);
    chk("underflow_no_pulse", op_done || op_err, 0);
    step(1, rtype(F_SLT), 32'hFFFFFFFF, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("slt_signed", op_done, 1);

    // Fill to DEPTH, drop one issue, then push+pop at full
    chk("no_overflow_yet", overflow, 0);
    for (int i = 0; i < DEPTH; i++) step(1, rtype(F_SUB), 32'(i * 3), 1, 0, 0);
    chk("full_not_ready", iss_ready, mq.size() < DEPTH);
    step(1, itype(OP_ADDI, 16'h0003), 4, 0, 0, 0);
    chk("overflow_set", overflow, 1);
    step(1, itype(OP_ADDI, 16'hFFFE), 10, 0, 1, 0);
    chk("full_after_pushpop", iss_ready, mq.size() < DEPTH);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 0);
    chk("drained_ready", iss_ready, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_inst(), rand_val(), rand_val(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, mq.size() > 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("random_pending", cq.size(), 0);

    // Reset arriving with a commit: queue flushed, pulse suppressed
    step(1, rtype(F_SUB), 9, 2, 0, 0);
    reset = 1; cmt_valid = 1; cmt_rd_value = 7;
    @(posedge clk);
    #1;
    reset = 0; cmt_valid = 0;
    mq.delete(); cq.delete(); mon_pass = 0; mon_fail = 0;
    chk("rst_mid_no_pulse", op_done || op_err, 0);
    chk("rst_mid_pass_cnt", pass_cnt, 0);
    chk("rst_mid_underflow", underflow, 0);
    chk("rst_mid_ready", iss_ready, 1);
    step(1, rtype(F_ADD), 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("rst_mid_fresh_queue", op_done, 1);

    // Halt-on-error instance
    h_reset = 0;
    h_iss_valid = 1; h_iss_inst = itype(OP_ADDI, 16'h0002); h_iss_rs = 9; h_iss_rt = 0;
    @(posedge clk); #1;
    h_iss_inst = rtype(F_ADD); h_iss_rs = 5; h_iss_rt = 7;
    @(posedge clk); #1;
    h_iss_valid = 0; h_cmt_valid = 1; h_cmt_rd = 99;
    @(posedge clk); #1;
    h_cmt_valid = 0;
    chk("halt_err", h_op_err, 1);
    chk("halt_err_opcode", h_err_opcode, OP_ADDI);
    chk("halt_fail_cnt", h_fail_cnt, 1);
    chk("halt_not_ready", h_iss_ready, 0);
    h_iss_valid = 1; h_iss_inst = rtype(F_ADD); h_cmt_valid = 1; h_cmt_rd = 12;
    @(posedge clk); #1;
    h_iss_valid = 0; h_cmt_valid = 0;
    chk("halt_ignores_commit", h_op_done || h_op_err, 0);
    chk("halt_pass_cnt", h_pass_cnt, 0);
    chk("halt_no_overflow", h_overflow, 0);
    @(posedge clk); #1;
    chk("halt_stays", h_iss_ready, 0);
    h_reset = 1;
    @(posedge clk); #1;
    h_reset = 0;
    chk("halt_rst_ready", h_iss_ready, 1);
    chk("halt_rst_fail_cnt", h_fail_cnt, 0);
    chk("halt_rst_err_opcode", h_err_opcode, 0);
    h_iss_valid = 1; h_iss_inst = rtype(F_ADD); h_iss_rs = 1; h_iss_rt = 1;
    @(posedge clk); #1;
    h_iss_valid = 0; h_cmt_valid = 1; h_cmt_rd = 2;
    @(posedge clk); #1;
    h_cmt_valid = 0;
    chk("halt_rst_fresh_queue", h_op_done, 1);
    chk("halt_rst_pass_cnt", h_pass_cnt, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_pulses", cq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
